bot_player: RTL

- Automated opponent that drives the game FSM's move interface (left/right/put single-cycle pulses) in place of the three debounced button pulse generators.
- Sits beside the button_input instances in the connect_four top, clocked on the VGA clock. Its outputs are ORed with the human pulses while bot mode is enabled.
- Reads the occupancy vectors and cursor column, picks a column, steps the cursor there at a visible rate, then drops the token.

---
 rtl/c4_pkg.sv | 17 +
 rtl/bot_player_if.sv | 32 +++
 rtl/c4_win_probe.sv | 43 ++++
 rtl/bot_player.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/c4_pkg.sv
// Shared Connect Four constants, board indexing and the bot FSM state type.
package c4_pkg;

    localparam int NUM_COLS  = 7;
    localparam int NUM_ROWS  = 6;
    localparam int NUM_CELLS = NUM_COLS * NUM_ROWS;

    // Centre-first column preference; entry 0 is scanned first.
    localparam logic [6:0][2:0] PREF_ORDER = {3'd6, 3'd0, 3'd5, 3'd1, 3'd4, 3'd2, 3'd3};

    typedef enum logic [2:0] {IDLE, WAIT, SCAN, MOVE, DROP, DONE} bot_state_t;

    function automatic int idx(input int row, input int col);
        return row * NUM_COLS + col;
    endfunction

endpackage

// File: rtl/bot_player_if.sv
// Game-side view of the bot: board/turn status in, move pulses and status out.
interface bot_player_if;
    import c4_pkg::*;

    logic                 which_player;
    logic                 anim_active;
    logic                 win_a;
    logic                 win_b;
    logic                 full_panel;
    logic                 invalid_detect;
    logic [2:0]           selected_col;
    logic [NUM_CELLS-1:0] color_p0;
    logic [NUM_CELLS-1:0] color_p1;
    logic                 left;
    logic                 right;
    logic                 put;
    logic                 busy;
    logic [2:0]           target_col;

    modport master (
        input  which_player, anim_active, win_a, win_b, full_panel, invalid_detect,
               selected_col, color_p0, color_p1,
        output left, right, put, busy, target_col
    );

    modport slave (
        output which_player, anim_active, win_a, win_b, full_panel, invalid_detect,
               selected_col, color_p0, color_p1,
        input  left, right, put, busy, target_col
    );

endinterface

// File: rtl/c4_win_probe.sv
// Combinational check: does placing a token at (row,col) on top of occ make four in a line?
module c4_win_probe
    import c4_pkg::*;
(
    input  logic [NUM_CELLS-1:0] occ,
    input  logic [2:0]           row,
    input  logic [2:0]           col,
    output logic                 win
);

    always_comb begin
        int   dr, dc, rr, cc, run;
        logic alive;
        win   = 1'b0;
        dr    = 0;
        dc    = 0;
        rr    = 0;
        cc    = 0;
        run   = 0;
        alive = 1'b0;
        // Directions: horizontal, vertical, rising diagonal, falling diagonal.
        for (int d = 0; d < 4; d++) begin
            dr  = (d == 0) ? 0 : 1;
            dc  = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
            run = 1;
            for (int s = -1; s <= 1; s += 2) begin
                alive = 1'b1;
                for (int k = 1; k <= 3; k++) begin
                    rr = int'(row) + s * k * dr;
                    cc = int'(col) + s * k * dc;
                    if (alive && rr >= 0 && rr < NUM_ROWS && cc >= 0 && cc < NUM_COLS) begin
                        if (occ[idx(rr, cc)]) run++;
                        else                  alive = 1'b0;
                    end else begin
                        alive = 1'b0;
                    end
                end
            end
            if (run >= 4) win = 1'b1;
        end
    end

endmodule

// File: rtl/bot_player.sv
// Automated opponent: waits, scans columns for win/block/legal, walks the cursor, drops.
module bot_player
    import c4_pkg::*;
#(
    parameter int BOT_SIDE     = 1,
    parameter int THINK_FRAMES = 30,
    parameter int STEP_FRAMES  = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic frame_tick,
    bot_player_if.master bus
);

    localparam int              TW        = $clog2(THINK_FRAMES + 1);
    localparam int              SW        = $clog2(STEP_FRAMES + 1);
    localparam logic [TW-1:0]   THINK_MAX = TW'(THINK_FRAMES);
    localparam logic [SW-1:0]   STEP_MAX  = SW'(STEP_FRAMES);
    localparam logic            SIDE      = (BOT_SIDE != 0);

    bot_state_t           state;
    logic [TW-1:0]        think_cnt;
    logic [SW-1:0]        step_cnt;
    logic [2:0]           scan_idx;
    logic                 have_win, have_blk, have_leg;
    logic [2:0]           win_col, blk_col, leg_col;

    logic                 go;
    logic [NUM_CELLS-1:0] occ_all, own, opp;
    logic [2:0]           cand_col, land_row, pick_col;
    logic                 cand_legal, bot_win, opp_win;
    logic                 nx_have_win, nx_have_blk, nx_have_leg;
    logic [2:0]           nx_win_col, nx_blk_col, nx_leg_col;

    assign go = enable & (bus.which_player == SIDE) & ~bus.anim_active
              & ~bus.win_a & ~bus.win_b & ~bus.full_panel;

    assign occ_all  = bus.color_p0 | bus.color_p1;
    assign own      = SIDE ? bus.color_p1 : bus.color_p0;
    assign opp      = SIDE ? bus.color_p0 : bus.color_p1;
    assign cand_col = PREF_ORDER[scan_idx];

    always_comb begin
        land_row   = '0;
        cand_legal = 1'b0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!occ_all[idx(r, int'(cand_col))]) begin
                land_row   = 3'(r);
                cand_legal = 1'b1;
            end
        end
    end

    c4_win_probe u_bot_probe (.occ(own), .row(land_row), .col(cand_col), .win(bot_win));
    c4_win_probe u_opp_probe (.occ(opp), .row(land_row), .col(cand_col), .win(opp_win));

    // First hit in preference order wins each category, so later hits never overwrite.
    assign nx_have_win = have_win | (cand_legal & bot_win);
    assign nx_have_blk = have_blk | (cand_legal & opp_win);
    assign nx_have_leg = have_leg | cand_legal;
    assign nx_win_col  = have_win ? win_col : cand_col;
    assign nx_blk_col  = have_blk ? blk_col : cand_col;
    assign nx_leg_col  = have_leg ? leg_col : cand_col;
    assign pick_col    = nx_have_win ? nx_win_col : (nx_have_blk ? nx_blk_col : nx_leg_col);

    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            think_cnt      <= '0;
            step_cnt       <= '0;
            scan_idx       <= '0;
            have_win       <= 1'b0;
            have_blk       <= 1'b0;
            have_leg       <= 1'b0;
            win_col        <= '0;
            blk_col        <= '0;
            leg_col        <= '0;
            bus.left       <= 1'b0;
            bus.right      <= 1'b0;
            bus.put        <= 1'b0;
            bus.target_col <= 3'd3;
        end else begin
            bus.left  <= 1'b0;
            bus.right <= 1'b0;
            bus.put   <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    state     <= WAIT;
                    think_cnt <= '0;
                end
                WAIT: if (!go) state <= IDLE;
                else if (think_cnt == THINK_MAX) begin
                    state    <= SCAN;
                    scan_idx <= '0;
                    have_win <= 1'b0;
                    have_blk <= 1'b0;
                    have_leg <= 1'b0;
                end else if (frame_tick) think_cnt <= think_cnt + 1'b1;
                SCAN: if (!go) state <= IDLE;
                else begin
                    have_win <= nx_have_win;
                    have_blk <= nx_have_blk;
                    have_leg <= nx_have_leg;
                    win_col  <= nx_win_col;
                    blk_col  <= nx_blk_col;
                    leg_col  <= nx_leg_col;
                    if (scan_idx == 3'(NUM_COLS - 1)) begin
                        if (nx_have_leg) begin
                            bus.target_col <= pick_col;
                            step_cnt       <= '0;
                            state          <= MOVE;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                // Counter clears only when a pulse goes out, so reaching the column
                // hands a saturated counter to DROP and the put follows at once.
                MOVE: if (!go) state <= IDLE;
                else if (step_cnt == STEP_MAX) begin
                    if (bus.selected_col < bus.target_col) begin
                        bus.right <= 1'b1;
                        step_cnt  <= '0;
                    end else if (bus.selected_col > bus.target_col) begin
                        bus.left <= 1'b1;
                        step_cnt <= '0;
                    end else begin
                        state <= DROP;
                    end
                end else if (frame_tick) step_cnt <= step_cnt + 1'b1;
                DROP: if (!go) state <= IDLE;
                else if (step_cnt == STEP_MAX) begin
                    bus.put  <= 1'b1;
                    step_cnt <= '0;
                    state    <= DONE;
                end else if (frame_tick) step_cnt <= step_cnt + 1'b1;
                DONE: if (!enable || bus.win_a || bus.win_b || bus.full_panel) state <= IDLE;
                else if (bus.invalid_detect) begin
                    state     <= WAIT;
                    think_cnt <= '0;
                end else if (bus.which_player != SIDE || bus.anim_active) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
